// File: rtl/instr_sequencer.sv
// Program sequencer: issues instructions from a host-loaded program memory over the DIN/Run/Done port.
// Optional Done watchdog with sticky Error: define INSTR_SEQUENCER_TIMEOUT_EN.
`timescale 1ns/1ps

module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [8:0]        LoadData,
  input  logic              Start,
  input  logic [ADDR_W:0]   ProgLen,
  input  logic              Done,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              Busy,
  output logic [ADDR_W-1:0] PC,
  output logic [7:0]        InstrCount,
  output logic              Error
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_IMM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
`ifdef INSTR_SEQUENCER_TIMEOUT_EN
  localparam logic [2:0] S_ERR   = 3'd4;
`endif

  localparam logic [2:0] OP_MVI = 3'b001;

  logic [8:0]        mem [DEPTH];
  logic [2:0]        state;
  logic [ADDR_W:0]   pc;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   pc_next;
  logic [7:0]        count;
  logic [ADDR_W-1:0] pc_idx;
  logic [ADDR_W-1:0] imm_idx;
  logic              busy;
  logic              start_ok;
  logic              wd_expired;

  assign busy     = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
  assign start_ok = Start && !busy;
  assign pc_idx   = pc[ADDR_W-1:0];
  assign imm_idx  = pc_idx + ADDR_W'(1);
  // One extra PC bit lets a full-memory program reach len instead of wrapping to 0.
  assign pc_next  = pc + ((state == S_IMM) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));

  // NOTE: program memory has no reset so it maps onto RAM and survives Reset.
  always_ff @(posedge Clock) begin
    if (LoadEn && !busy) mem[LoadAddr] <= LoadData;
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= '0;
      len   <= '0;
      count <= '0;
    end else if (start_ok) begin
      count <= '0;
      if (ProgLen != '0) begin
        pc    <= '0;
        len   <= ProgLen;
        state <= S_ISSUE;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_ISSUE: state <= (mem[pc_idx][2:0] == OP_MVI) ? S_IMM : S_WAIT;
        S_IMM, S_WAIT: begin
          if (Done) begin
            pc    <= pc_next;
            count <= (count == 8'hFF) ? count : count + 8'd1;
            state <= (pc_next >= len) ? S_IDLE : S_ISSUE;
          end else if (wd_expired) begin
`ifdef INSTR_SEQUENCER_TIMEOUT_EN
            state <= S_ERR;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifdef INSTR_SEQUENCER_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [WD_W-1:0] wdog;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                          wdog <= '0;
    else if (state == S_ISSUE)                          wdog <= '0;
    else if ((state == S_IMM || state == S_WAIT) && !Done) wdog <= wdog + WD_W'(1);
  end

  assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));
  assign Error      = (state == S_ERR);
`else
  assign wd_expired = 1'b0;
  assign Error      = 1'b0;
`endif

  // NOTE: DIN gets a default first so the combinational block never infers a latch.
  always_comb begin
    DIN = '0;
    case (state)
      S_ISSUE, S_WAIT: DIN = mem[pc_idx];
      S_IMM:           DIN = mem[imm_idx];
      default:         DIN = '0;
    endcase
  end

  assign Run        = (state == S_ISSUE);
  assign Busy       = busy;
  assign PC         = pc_idx;
  assign InstrCount = count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (ADDR_W=2, TIMEOUT=15) with a Done-latency processor stand-in.
`timescale 1ns/1ps

module tb_instr_sequencer;

  localparam int AW = 2;

  logic          Clock, Reset, LoadEn, Start, Done;
  logic [AW-1:0] LoadAddr;
  logic [8:0]    LoadData;
  logic [AW:0]   ProgLen;
  logic [8:0]    DIN;
  logic          Run, Busy, Error;
  logic [AW-1:0] PC;
  logic [7:0]    InstrCount;

  int n_checks = 0;
  int n_pass   = 0;
  bit auto_done = 1'b1;
  int done_lat  = 1;
  int done_cnt  = 0;

  instr_sequencer #(.ADDR_W(AW), .TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .Start(Start), .ProgLen(ProgLen), .Done(Done),
    .DIN(DIN), .Run(Run), .Busy(Busy), .PC(PC), .InstrCount(InstrCount),
    .Error(Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Processor stand-in: Done is high for one cycle, done_lat cycles after the Run cycle.
  always @(negedge Clock) begin
    if (auto_done) begin
      if (Run) begin
        done_cnt = done_lat;
        Done     = 1'b0;
      end else if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        Done     = (done_cnt == 0);
      end else begin
        Done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish by 100000ns");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [8:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    Start = 1'b1; ProgLen = len;
    tick();
    Start = 1'b0;
  endtask

  task automatic manual_done(input bit on);
    auto_done = !on;
    done_cnt  = 0;
    Done      = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; LoadEn = 1'b0; Start = 1'b0; Done = 1'b0;
    LoadAddr = '0; LoadData = '0; ProgLen = '0;
    #12;
    n_checks++; if (Run !== 1'b0) $display("FAIL reset_run: got %b want 0", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h000) $display("FAIL reset_din: got %h want 000", DIN); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (PC !== '0) $display("FAIL reset_pc: got %0d want 0", PC); else n_pass++;
    n_checks++; if (InstrCount !== 8'd0) $display("FAIL reset_count: got %0d want 0", InstrCount); else n_pass++;
    n_checks++; if (Error !== 1'b0) $display("FAIL reset_error: got %b want 0", Error); else n_pass++;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_mvi_program();
    logic       exp_run  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0] exp_din  [5] = '{9'h001, 9'h0A5, 9'h088, 9'h088, 9'h000};
    logic       exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    load_word(2'd0, 9'h001);
    load_word(2'd1, 9'h0A5);
    load_word(2'd2, 9'h088);
    done_lat = 1;
    pulse_start(3'd3);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (Run !== exp_run[i]) $display("FAIL mvi_run[%0d]: got %b want %b", i, Run, exp_run[i]); else n_pass++;
      n_checks++; if (DIN !== exp_din[i]) $display("FAIL mvi_din[%0d]: got %h want %h", i, DIN, exp_din[i]); else n_pass++;
      n_checks++; if (Busy !== exp_busy[i]) $display("FAIL mvi_busy[%0d]: got %b want %b", i, Busy, exp_busy[i]); else n_pass++;
      tick();
    end
    n_checks++; if (InstrCount !== 8'd2) $display("FAIL mvi_count: got %0d want 2", InstrCount); else n_pass++;
    n_checks++; if (PC !== 2'd3) $display("FAIL mvi_pc: got %0d want 3", PC); else n_pass++;
  endtask

  task automatic test_add_latency();
    logic       exp_run  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [8:0] exp_din  [5] = '{9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h000};
    logic       exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    load_word(2'd0, 9'h04A);
    done_lat = 3;
    pulse_start(3'd1);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (Run !== exp_run[i]) $display("FAIL add_run[%0d]: got %b want %b", i, Run, exp_run[i]); else n_pass++;
      n_checks++; if (DIN !== exp_din[i]) $display("FAIL add_din[%0d]: got %h want %h", i, DIN, exp_din[i]); else n_pass++;
      n_checks++; if (Busy !== exp_busy[i]) $display("FAIL add_busy[%0d]: got %b want %b", i, Busy, exp_busy[i]); else n_pass++;
      tick();
    end
    n_checks++; if (InstrCount !== 8'd1) $display("FAIL add_count: got %0d want 1", InstrCount); else n_pass++;
    done_lat = 1;
  endtask

  task automatic test_reset_mid_program();
    load_word(2'd0, 9'h040);
    manual_done(1);
    pulse_start(3'd1);
    tick();
    n_checks++; if (Busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", Busy); else n_pass++;
    Reset = 1'b1;
    #1;
    n_checks++; if (Run !== 1'b0) $display("FAIL midrst_run: got %b want 0", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h000) $display("FAIL midrst_din: got %h want 000", DIN); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (PC !== '0) $display("FAIL midrst_pc: got %0d want 0", PC); else n_pass++;
    n_checks++; if (InstrCount !== 8'd0) $display("FAIL midrst_count: got %0d want 0", InstrCount); else n_pass++;
    tick();
    Reset = 1'b0;
    tick();
    manual_done(0);
    pulse_start(3'd1);
    n_checks++; if (Run !== 1'b1) $display("FAIL midrst_restart_run: got %b want 1", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h040) $display("FAIL midrst_mem_kept: got %h want 040", DIN); else n_pass++;
    tick(); tick();
    n_checks++; if (Busy !== 1'b0) $display("FAIL midrst_end_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (InstrCount !== 8'd1) $display("FAIL midrst_end_count: got %0d want 1", InstrCount); else n_pass++;
  endtask

  task automatic test_zero_len();
    pulse_start(3'd0);
    n_checks++; if (Run !== 1'b0) $display("FAIL zlen_run: got %b want 0", Run); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL zlen_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (InstrCount !== 8'd0) $display("FAIL zlen_count: got %0d want 0", InstrCount); else n_pass++;
    tick();
    n_checks++; if (Run !== 1'b0) $display("FAIL zlen_run_later: got %b want 0", Run); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL zlen_busy_later: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    manual_done(1);
    pulse_start(3'd1);
    tick();
    Start = 1'b1; ProgLen = 3'd3;
    LoadEn = 1'b1; LoadAddr = 2'd0; LoadData = 9'h1FF;
    tick();
    Start = 1'b0; LoadEn = 1'b0;
    n_checks++; if (Busy !== 1'b1) $display("FAIL busy_ign_busy: got %b want 1", Busy); else n_pass++;
    n_checks++; if (Run !== 1'b0) $display("FAIL busy_ign_run: got %b want 0", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h040) $display("FAIL busy_ign_din: got %h want 040", DIN); else n_pass++;
    Done = 1'b1;
    tick();
    Done = 1'b0;
    n_checks++; if (Busy !== 1'b0) $display("FAIL busy_ign_end_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (InstrCount !== 8'd1) $display("FAIL busy_ign_count: got %0d want 1", InstrCount); else n_pass++;
    manual_done(0);
    pulse_start(3'd1);
    n_checks++; if (DIN !== 9'h040) $display("FAIL busy_ign_mem: got %h want 040", DIN); else n_pass++;
    n_checks++; if (Run !== 1'b1) $display("FAIL busy_ign_rerun: got %b want 1", Run); else n_pass++;
    tick(); tick();
    n_checks++; if (Busy !== 1'b0) $display("FAIL busy_ign_rerun_end: got %b want 0", Busy); else n_pass++;
  endtask

  task automatic test_full_memory();
    logic [8:0] exp_issue [4] = '{9'h008, 9'h050, 9'h098, 9'h0E0};
    logic [8:0] seen      [4] = '{9'h000, 9'h000, 9'h000, 9'h000};
    int runs = 0;
    load_word(2'd0, 9'h008);
    load_word(2'd1, 9'h050);
    load_word(2'd2, 9'h098);
    load_word(2'd3, 9'h0E0);
    pulse_start(3'd4);
    for (int i = 0; i < 12; i++) begin
      if (Run === 1'b1) begin
        if (runs < 4) seen[runs] = DIN;
        runs++;
      end
      tick();
    end
    n_checks++; if (runs !== 4) $display("FAIL full_run_pulses: got %0d want 4", runs); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (seen[i] !== exp_issue[i]) $display("FAIL full_issue[%0d]: got %h want %h", i, seen[i], exp_issue[i]); else n_pass++;
    end
    n_checks++; if (Busy !== 1'b0) $display("FAIL full_busy: got %b want 0", Busy); else n_pass++;
    n_checks++; if (InstrCount !== 8'd4) $display("FAIL full_count: got %0d want 4", InstrCount); else n_pass++;
    n_checks++; if (PC !== 2'd0) $display("FAIL full_pc: got %0d want 0", PC); else n_pass++;
  endtask

  task automatic test_last_word_mvi();
    logic       exp_run  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [8:0] exp_din  [9] = '{9'h008, 9'h008, 9'h050, 9'h050, 9'h098, 9'h098, 9'h001, 9'h008, 9'h000};
    logic       exp_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    load_word(2'd3, 9'h001);
    pulse_start(3'd4);
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (Run !== exp_run[i]) $display("FAIL lastmvi_run[%0d]: got %b want %b", i, Run, exp_run[i]); else n_pass++;
      n_checks++; if (DIN !== exp_din[i]) $display("FAIL lastmvi_din[%0d]: got %h want %h", i, DIN, exp_din[i]); else n_pass++;
      n_checks++; if (Busy !== exp_busy[i]) $display("FAIL lastmvi_busy[%0d]: got %b want %b", i, Busy, exp_busy[i]); else n_pass++;
      tick();
    end
    n_checks++; if (InstrCount !== 8'd4) $display("FAIL lastmvi_count: got %0d want 4", InstrCount); else n_pass++;
  endtask

  task automatic test_timeout();
    manual_done(1);
    pulse_start(3'd1);
`ifdef INSTR_SEQUENCER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (Error !== 1'b0) $display("FAIL tmo_error_early: got %b want 0", Error); else n_pass++;
    n_checks++; if (Busy !== 1'b1) $display("FAIL tmo_busy_early: got %b want 1", Busy); else n_pass++;
    tick();
    n_checks++; if (Error !== 1'b1) $display("FAIL tmo_error: got %b want 1", Error); else n_pass++;
    n_checks++; if (Run !== 1'b0) $display("FAIL tmo_run: got %b want 0", Run); else n_pass++;
    n_checks++; if (Busy !== 1'b0) $display("FAIL tmo_busy: got %b want 0", Busy); else n_pass++;
    tick();
    n_checks++; if (Error !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", Error); else n_pass++;
    pulse_start(3'd1);
    n_checks++; if (Error !== 1'b0) $display("FAIL tmo_restart_error: got %b want 0", Error); else n_pass++;
    n_checks++; if (Run !== 1'b1) $display("FAIL tmo_restart_run: got %b want 1", Run); else n_pass++;
    n_checks++; if (DIN !== 9'h008) $display("FAIL tmo_restart_din: got %h want 008", DIN); else n_pass++;
    tick();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    n_checks++; if (Busy !== 1'b0) $display("FAIL tmo_restart_end: got %b want 0", Busy); else n_pass++;
`else
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (Error !== 1'b0) $display("FAIL notmo_error: got %b want 0", Error); else n_pass++;
    n_checks++; if (Busy !== 1'b1) $display("FAIL notmo_busy: got %b want 1", Busy); else n_pass++;
    n_checks++; if (Run !== 1'b0) $display("FAIL notmo_run: got %b want 0", Run); else n_pass++;
    Reset = 1'b1;
    #1;
    n_checks++; if (Busy !== 1'b0) $display("FAIL notmo_reset_busy: got %b want 0", Busy); else n_pass++;
    tick();
    Reset = 1'b0;
    tick();
`endif
    manual_done(0);
  endtask

  initial begin
    test_reset();
    test_mvi_program();
    test_add_latency();
    test_reset_mid_program();
    test_zero_len();
    test_busy_ignore();
    test_full_memory();
    test_last_word_mvi();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
